// File: rtl/scs8hd_a22oi_bist.sv
`timescale 1ns/1ps
// Purpose : self-test sequencer for one AOI22 cell (Y = !((A1&A2)|(B1&B2))).
//           It sweeps all 16 input vectors, waits a settle window, checks Y,
//           counts errors and folds every Y sample into a 16-bit MISR.
// Latency : DONE rises PASSES*16*(SETTLE_CYCLES+1) edges after the edge that samples START.
// Backpr. : none; START is honoured only in IDLE/DONE and ignored while BUSY.
// Ports   : CLK, RESET (sync, active-high), START, Y_IN (cell output)
//           -> A1/A2/B1/B2 (cell drives), BUSY, DONE, PASS, ERR_CNT,
//              ERR_FIRST_VEC, SIGNATURE. Every output comes from a flop.
module scs8hd_a22oi_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,   // 1..255
  parameter int unsigned PASSES        = 1,   // 1..15
  parameter int unsigned ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             Y_IN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       ERR_FIRST_VEC,
  output logic [15:0]      SIGNATURE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       LAST_PASS   = 4'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [15:0]      MISR_SEED   = 16'hFFFF;
  localparam logic [15:0]      MISR_POLY   = 16'h1021;

  state_t      state;
  logic [7:0]  settle_cnt;
  logic [3:0]  pass_cnt;
  logic [3:0]  vec;

  // Sample-cycle evaluation. Y_IN only reaches flops through these terms.
  logic        exp_y;
  logic        mismatch;
  logic        y_one;
  logic        fb;
  logic [15:0] sig_next;
  logic        last_vec;

  always_comb begin
    exp_y    = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    // Case inequality so that an X/Z from the cell is always a failure.
    mismatch = (Y_IN !== exp_y);
    // Only a clean 1 feeds the MISR as 1; X/Z fold in as 0.
    y_one    = (Y_IN === 1'b1);
    fb       = SIGNATURE[15] ^ y_one;
    sig_next = {SIGNATURE[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    last_vec = (vec == 4'hF) && (pass_cnt == LAST_PASS);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      settle_cnt    <= 8'd0;
      pass_cnt      <= 4'd0;
      vec           <= 4'd0;
      {A1, A2, B1, B2} <= 4'h0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      PASS          <= 1'b0;
      ERR_CNT       <= '0;
      ERR_FIRST_VEC <= 4'd0;
      SIGNATURE     <= MISR_SEED;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state         <= S_SETTLE;
            settle_cnt    <= SETTLE_LOAD;
            pass_cnt      <= 4'd0;
            vec           <= 4'd0;
            {A1, A2, B1, B2} <= 4'h0;
            BUSY          <= 1'b1;
            DONE          <= 1'b0;
            PASS          <= 1'b0;
            ERR_CNT       <= '0;
            ERR_FIRST_VEC <= 4'd0;
            SIGNATURE     <= MISR_SEED;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        S_SAMPLE: begin
          SIGNATURE <= sig_next;
          if (mismatch) begin
            if (ERR_CNT != ERR_MAX) begin
              ERR_CNT <= ERR_CNT + ERR_W'(1);
            end
            if (ERR_CNT == '0) begin
              ERR_FIRST_VEC <= vec;
            end
          end

          if (last_vec) begin
            state            <= S_DONE;
            {A1, A2, B1, B2} <= 4'h0;
            BUSY             <= 1'b0;
            DONE             <= 1'b1;
            // Final count is zero only if it was zero and this sample matched;
            // a saturating increment never wraps back to zero.
            PASS             <= (ERR_CNT == '0) && !mismatch;
          end else begin
            state            <= S_SETTLE;
            settle_cnt       <= SETTLE_LOAD;
            vec              <= vec + 4'd1;
            {A1, A2, B1, B2} <= vec + 4'd1;
            if (vec == 4'hF) begin
              pass_cnt <= pass_cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scs8hd_a22oi_bist.sv
`timescale 1ns/1ps
module tb_scs8hd_a22oi_bist;

  typedef struct {
    logic        pass;
    logic [7:0]  err;
    logic [3:0]  first;
    logic [15:0] sig;
    int          busy;
  } exp_t;

  // Hand-tabulated AOI22 output for vec 0..15, vec 0 in the MSB.
  localparam logic [15:0] GOLD   = 16'b1110_1110_1110_0000;
  localparam int          M_GOLD = 0;
  localparam int          M_ONE  = 1;
  localparam int          M_ZERO = 2;
  localparam int          M_X5   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  logic xval  = 1'bx;
  logic fin1  = 1'b0;
  logic fin2  = 1'b0;

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];
  logic [3:0] dq2[$];

  // ---------------- DUT 0: default parameters ----------------
  logic rst0 = 1'b1, st0 = 1'b0, y0;
  logic a1_0, a2_0, b1_0, b2_0, busy0, done0, pass0;
  logic [7:0]  err0;
  logic [3:0]  fv0, drv0;
  logic [15:0] sig0;
  int          mode0 = M_GOLD;
  assign drv0 = {a1_0, a2_0, b1_0, b2_0};
  always_comb y0 = cell_y(mode0, drv0);

  scs8hd_a22oi_bist d0 (
    .CLK(clk), .RESET(rst0), .START(st0), .Y_IN(y0),
    .A1(a1_0), .A2(a2_0), .B1(b1_0), .B2(b2_0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0), .ERR_FIRST_VEC(fv0), .SIGNATURE(sig0)
  );

  // ---------------- DUT 1: two passes, 3-bit error counter, Y stuck 0 ----------------
  logic rst1 = 1'b1, st1 = 1'b0;
  logic y1;
  logic a1_1, a2_1, b1_1, b2_1, busy1, done1, pass1;
  logic [2:0]  err1;
  logic [3:0]  fv1;
  logic [15:0] sig1;
  assign y1 = 1'b0;

  scs8hd_a22oi_bist #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(3)) d1 (
    .CLK(clk), .RESET(rst1), .START(st1), .Y_IN(y1),
    .A1(a1_1), .A2(a2_1), .B1(b1_1), .B2(b2_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1), .ERR_FIRST_VEC(fv1), .SIGNATURE(sig1)
  );

  // ---------------- DUT 2: one settle cycle, golden cell ----------------
  logic rst2 = 1'b1, st2 = 1'b0, y2;
  logic a1_2, a2_2, b1_2, b2_2, busy2, done2, pass2;
  logic [7:0]  err2;
  logic [3:0]  fv2, drv2;
  logic [15:0] sig2;
  assign drv2 = {a1_2, a2_2, b1_2, b2_2};
  always_comb y2 = cell_y(M_GOLD, drv2);

  scs8hd_a22oi_bist #(.SETTLE_CYCLES(1)) d2 (
    .CLK(clk), .RESET(rst2), .START(st2), .Y_IN(y2),
    .A1(a1_2), .A2(a2_2), .B1(b1_2), .B2(b2_2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(err2), .ERR_FIRST_VEC(fv2), .SIGNATURE(sig2)
  );

  // ---------------- helpers ----------------
  function automatic logic gold_y(input logic [3:0] v);
    logic [15:0] t;
    t = GOLD;
    return t[4'd15 - v];
  endfunction

  function automatic logic cell_y(input int mode, input logic [3:0] v);
    case (mode)
      M_ONE:   return 1'b1;
      M_ZERO:  return 1'b0;
      M_X5:    return (v == 4'd5) ? xval : gold_y(v);
      default: return gold_y(v);
    endcase
  endfunction

  // Reference run: error count/first index and MISR over the Y sequence.
  function automatic exp_t model(input int mode, input int passes, input int err_w, input int busy);
    exp_t e;
    int   cnt;
    logic y, g, fb;
    e.sig   = 16'hFFFF;
    e.first = 4'd0;
    cnt     = 0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 16; v++) begin
        y = cell_y(mode, 4'(v));
        g = gold_y(4'(v));
        if (y !== g) begin
          if (cnt == 0) e.first = 4'(v);
          if (cnt < (1 << err_w) - 1) cnt++;
        end
        fb    = e.sig[15] ^ (y === 1'b1);
        e.sig = {e.sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    e.err  = 8'(cnt);
    e.pass = (cnt == 0);
    e.busy = busy;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic p, input logic [7:0] err,
                     input logic [3:0] fv, input logic [15:0] sig, input int bc);
    chk({tag, " PASS"},      32'(p),   32'(e.pass));
    chk({tag, " ERR_CNT"},   32'(err), 32'(e.err));
    chk({tag, " FIRST_VEC"}, 32'(fv),  32'(e.first));
    chk({tag, " SIGNATURE"}, 32'(sig), 32'(e.sig));
    chk({tag, " latency"},   32'(bc),  32'(e.busy));
  endtask

  // ---------------- monitors ----------------
  int   bc0 = 0, bc1 = 0, bc2 = 0;
  logic dp0 = 1'b0, dp1 = 1'b0, dp2 = 1'b0;

  always @(negedge clk) begin
    if (rst0) bc0 = 0; else if (busy0) bc0++;
    if (done0 && !dp0) begin
      if (q0.size() == 0) chk("d0 unexpected DONE", 32'd1, 32'd0);
      else cmp("d0", q0.pop_front(), pass0, err0, fv0, sig0, bc0);
      bc0 = 0;
    end
    dp0 = done0;
  end

  always @(negedge clk) begin
    if (rst1) bc1 = 0; else if (busy1) bc1++;
    if (done1 && !dp1) begin
      if (q1.size() == 0) chk("d1 unexpected DONE", 32'd1, 32'd0);
      else cmp("d1", q1.pop_front(), pass1, 8'(err1), fv1, sig1, bc1);
      bc1 = 0;
    end
    dp1 = done1;
  end

  always @(negedge clk) begin
    if (rst2) bc2 = 0;
    else if (busy2) begin
      bc2++;
      if (dq2.size() == 0) chk("d2 drive extra", 32'd1, 32'd0);
      else chk("d2 drive", 32'(drv2), 32'(dq2.pop_front()));
    end
    if (done2 && !dp2) begin
      if (q2.size() == 0) chk("d2 unexpected DONE", 32'd1, 32'd0);
      else cmp("d2", q2.pop_front(), pass2, err2, fv2, sig2, bc2);
      bc2 = 0;
    end
    dp2 = done2;
  end

  // ---------------- DUT 0 stimulus ----------------
  task automatic go0(input int mode, input exp_t e);
    mode0 = mode;
    q0.push_back(e);
    st0 = 1'b1;
    tick(1);
    st0 = 1'b0;
  endtask

  task automatic wait0(input int budget);
    for (int i = 0; i < budget && !done0; i++) tick(1);
    chk("d0 done timeout", 32'(done0), 32'd1);
    tick(2);
  endtask

  initial begin
    exp_t e;
    // START held high together with RESET: reset must win.
    st0 = 1'b1;
    tick(3);
    chk("rst BUSY",      32'(busy0), 32'd0);
    chk("rst DONE",      32'(done0), 32'd0);
    chk("rst PASS",      32'(pass0), 32'd0);
    chk("rst drives",    32'(drv0),  32'd0);
    chk("rst ERR_CNT",   32'(err0),  32'd0);
    chk("rst FIRST_VEC", 32'(fv0),   32'd0);
    chk("rst SIGNATURE", 32'(sig0),  32'hFFFF);
    st0  = 1'b0;
    rst0 = 1'b0;
    tick(2);

    e = model(M_GOLD, 1, 8, 48);
    go0(M_GOLD, e);
    chk("BUSY after START", 32'(busy0), 32'd1);
    wait0(100);

    e = model(M_ONE, 1, 8, 48);
    e.err = 8'd7; e.first = 4'd3; e.pass = 1'b0;
    go0(M_ONE, e);
    wait0(100);

    e = model(M_ZERO, 1, 8, 48);
    e.err = 8'd9; e.first = 4'd0; e.pass = 1'b0;
    go0(M_ZERO, e);
    wait0(100);

    e = model(M_X5, 1, 8, 48);
    go0(M_X5, e);
    wait0(100);

    // Restart from DONE with clean results; a START pulse mid-run is ignored.
    e = model(M_GOLD, 1, 8, 48);
    go0(M_GOLD, e);
    tick(10);
    st0 = 1'b1;
    tick(3);
    st0 = 1'b0;
    wait0(100);

    // Abort during vec 9 with errors already logged.
    mode0 = M_ZERO;
    st0 = 1'b1;
    tick(1);
    st0 = 1'b0;
    for (int i = 0; i < 200 && drv0 != 4'd9; i++) tick(1);
    chk("reach vec9", 32'(drv0), 32'd9);
    rst0 = 1'b1;
    tick(1);
    chk("midrst BUSY",      32'(busy0), 32'd0);
    chk("midrst DONE",      32'(done0), 32'd0);
    chk("midrst drives",    32'(drv0),  32'd0);
    chk("midrst ERR_CNT",   32'(err0),  32'd0);
    chk("midrst SIGNATURE", 32'(sig0),  32'hFFFF);
    rst0 = 1'b0;
    tick(2);
    chk("midrst stays idle", 32'(busy0), 32'd0);

    e = model(M_GOLD, 1, 8, 48);
    go0(M_GOLD, e);
    wait0(100);

    for (int i = 0; i < 500 && !(fin1 && fin2); i++) tick(1);
    chk("side runs finished", 32'({fin1, fin2}), 32'd3);
    chk("q0 drained",  32'(q0.size()),  32'd0);
    chk("q1 drained",  32'(q1.size()),  32'd0);
    chk("q2 drained",  32'(q2.size()),  32'd0);
    chk("dq2 drained", 32'(dq2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- DUT 1 stimulus: saturation ----------------
  initial begin
    exp_t e;
    tick(2);
    rst1 = 1'b0;
    tick(1);
    e = model(M_ZERO, 2, 3, 96);
    e.err = 8'd7; e.first = 4'd0; e.pass = 1'b0;
    q1.push_back(e);
    st1 = 1'b1;
    tick(1);
    st1 = 1'b0;
    for (int i = 0; i < 200 && !done1; i++) tick(1);
    chk("d1 done timeout", 32'(done1), 32'd1);
    tick(2);
    fin1 = 1'b1;
  end

  // ---------------- DUT 2 stimulus: short settle, drive order ----------------
  initial begin
    exp_t e;
    tick(2);
    rst2 = 1'b0;
    tick(1);
    e = model(M_GOLD, 1, 8, 32);
    q2.push_back(e);
    for (int v = 0; v < 16; v++) begin
      dq2.push_back(4'(v));
      dq2.push_back(4'(v));
    end
    st2 = 1'b1;
    tick(1);
    st2 = 1'b0;
    for (int i = 0; i < 100 && !done2; i++) tick(1);
    chk("d2 done timeout", 32'(done2), 32'd1);
    chk("d2 drives idle in DONE", 32'(drv2), 32'd0);
    tick(2);
    fin2 = 1'b1;
  end

endmodule
